// File: rtl/task_input_pkt_buffer_if.sv
// Stream bundle for task_input_pkt_buffer: upstream packet input, downstream replay and status.
// slave is the buffer side, master is the host/test side.
interface task_input_pkt_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
);
  localparam int LEN_W = $clog2(DEPTH) + 1;

  logic              i_tdata_valid;
  logic [DATA_W-1:0] i_tdata;
  logic              i_tdata_last;
  logic              o_tready;
  logic              i_output_last;
  logic              o_tvalid;
  logic [DATA_W-1:0] o_tdata;
  logic              o_tlast;
  logic              i_tready;
  logic              o_busy;
  logic              o_empty;
  logic [LEN_W-1:0]  o_pkt_len;
  logic              o_overflow;

  modport slave (
    input  i_tdata_valid, i_tdata, i_tdata_last, i_output_last, i_tready,
    output o_tready, o_tvalid, o_tdata, o_tlast, o_busy, o_empty, o_pkt_len, o_overflow
  );

  modport master (
    output i_tdata_valid, i_tdata, i_tdata_last, i_output_last, i_tready,
    input  o_tready, o_tvalid, o_tdata, o_tlast, o_busy, o_empty, o_pkt_len, o_overflow
  );
endinterface

// File: rtl/task_input_pkt_buffer.sv
// Requests one packet from upstream, stores it in a FIFO (truncating beyond DEPTH),
// then replays it downstream with valid/ready and tlast on the last stored word.
module task_input_pkt_buffer #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int AUTO_REQ = 1
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  task_input_pkt_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_s;
  logic              empty_r;
  logic              req_pend_r;
  logic              tready_r;
  logic              tvalid_r;
  logic              tlast_r;
  logic [DATA_W-1:0] tdata_r;
  logic              busy_r;
  logic [CW-1:0]     pkt_len_r;
  logic              overflow_r;

  logic full_s;
  logic accept_s;
  logic last_beat_s;
  logic wr_en_s;
  logic rd_en_s;
  logic fire_s;
  logic done_s;
  logic start_s;

  // Next-state and datapath strobes
  always_comb begin
    state_s     = state_r;
    full_s      = (count_r == CW'(DEPTH));
    accept_s    = (state_r == LOAD) && tready_r && bus.i_tdata_valid;
    last_beat_s = accept_s && bus.i_tdata_last;
    wr_en_s     = accept_s && !full_s;
    fire_s      = tvalid_r && bus.i_tready;
    done_s      = fire_s && tlast_r;
    // The output register refills whenever it is empty or being drained this cycle.
    rd_en_s     = (state_r == SEND) && (count_r != {CW{1'b0}}) && (!tvalid_r || bus.i_tready);
    start_s     = 1'b0;
    if (wr_en_s) begin
      count_s = count_r + CW'(1);
    end else if (rd_en_s) begin
      count_s = count_r - CW'(1);
    end else begin
      count_s = count_r;
    end
    case (state_r)
      IDLE: begin
        if (empty_r && req_pend_r) begin
          state_s = REQ;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      REQ:  state_s = LOAD;
      LOAD: begin
        if (last_beat_s) state_s = SEND;
        else             state_s = LOAD;
      end
      SEND: begin
        if (done_s) state_s = IDLE;
        else        state_s = SEND;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // FIFO storage (no reset on the array so it maps to RAM)
  always_ff @(posedge i_clk) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= bus.i_tdata;
  end

  // FIFO pointers, occupancy and empty flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      empty_r  <= 1'b1;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      else         wr_ptr_r <= wr_ptr_r;
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      else         rd_ptr_r <= rd_ptr_r;
      count_r <= count_s;
      empty_r <= (count_s == {CW{1'b0}});
    end
  end

  // Request tracking, handshake and status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_pend_r <= (AUTO_REQ != 0);
      tready_r   <= 1'b0;
      busy_r     <= 1'b0;
      pkt_len_r  <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      // A new request wins over the clear so a pulse is never dropped.
      if (bus.i_output_last) req_pend_r <= 1'b1;
      else if (start_s)      req_pend_r <= 1'b0;
      else                   req_pend_r <= req_pend_r;
      if (state_r == REQ)   tready_r <= 1'b1;
      else if (last_beat_s) tready_r <= 1'b0;
      else                  tready_r <= tready_r;
      if (start_s)     busy_r <= 1'b1;
      else if (done_s) busy_r <= 1'b0;
      else             busy_r <= busy_r;
      if (last_beat_s) pkt_len_r <= wr_en_s ? (count_r + CW'(1)) : count_r;
      else             pkt_len_r <= pkt_len_r;
      if (accept_s && full_s) overflow_r <= 1'b1;
      else                    overflow_r <= overflow_r;
    end
  end

  // Single-register downstream output stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      tdata_r  <= {DATA_W{1'b0}};
    end else if (done_s) begin
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      tdata_r  <= tdata_r;
    end else if (rd_en_s) begin
      tvalid_r <= 1'b1;
      tlast_r  <= (count_r == CW'(1));
      tdata_r  <= mem_r[rd_ptr_r];
    end else if (fire_s) begin
      tvalid_r <= 1'b0;
      tlast_r  <= tlast_r;
      tdata_r  <= tdata_r;
    end else begin
      tvalid_r <= tvalid_r;
      tlast_r  <= tlast_r;
      tdata_r  <= tdata_r;
    end
  end

  assign bus.o_tready   = tready_r;
  assign bus.o_tvalid   = tvalid_r;
  assign bus.o_tdata    = tdata_r;
  assign bus.o_tlast    = tlast_r;
  assign bus.o_busy     = busy_r;
  assign bus.o_empty    = empty_r;
  assign bus.o_pkt_len  = pkt_len_r;
  assign bus.o_overflow = overflow_r;
endmodule
